// File: rtl/si_mac.sv
// Sequential sign-magnitude multiply-accumulate: shift-add product per term, saturating
// two's-complement accumulator, saturated sign-magnitude result on the last term.
module si_mac #(
  parameter int N     = 8,
  parameter int FRAC  = 0,
  parameter int ACC_W = 24
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         IN_LAST,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] RESULT,
  output logic         OVF
);

  localparam int M  = N - 1;
  localparam int PW = 2 * N - 2;
  localparam int CW = $clog2(N);
  localparam logic signed [ACC_W:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            mcand_q, mcand_d;
  logic [PW-1:0]            prod_q, prod_d;
  logic [M-1:0]             mplier_q, mplier_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     neg_q, neg_d;
  logic                     last_q, last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sticky_q, sticky_d;
  logic [N-1:0]             result_q, result_d;
  logic                     ovf_q, ovf_d;

  logic [PW-1:0]            scaled;
  logic signed [ACC_W:0]    term, sum;
  logic signed [ACC_W-1:0]  acc_new;
  logic [ACC_W-1:0]         abs_v;
  logic                     sat, clamp;

  // Datapath for the ACC cycle: scale, apply sign, saturating add, output conversion.
  always_comb begin
    scaled  = prod_q >> FRAC;
    term    = $signed({{(ACC_W+1-PW){1'b0}}, scaled});
    if (neg_q) term = -term;
    sum     = $signed({acc_q[ACC_W-1], acc_q}) + term;
    sat     = 1'b0;
    acc_new = sum[ACC_W-1:0];
    if (sum > ACC_MAX) begin
      sat     = 1'b1;
      acc_new = ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      sat     = 1'b1;
      acc_new = ACC_MIN[ACC_W-1:0];
    end
    // acc_new never reaches -2^(ACC_W-1), so its negation always fits.
    abs_v = acc_new[ACC_W-1] ? -acc_new : acc_new;
    clamp = |abs_v[ACC_W-1:N-1];
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    last_d   = last_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          mcand_d  = {{(PW-M){1'b0}}, A[M-1:0]};
          mplier_d = B[M-1:0];
          prod_d   = '0;
          cnt_d    = '0;
          neg_d    = A[N-1] ^ B[N-1];
          last_d   = IN_LAST;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 2)) state_d = ACC;
      end
      ACC: begin
        acc_d    = acc_new;
        sticky_d = sticky_q | sat;
        if (last_q) begin
          result_d = {acc_new[ACC_W-1], clamp ? {(N-1){1'b1}} : abs_v[N-2:0]};
          ovf_d    = clamp | sticky_q | sat;
          state_d  = DONE;
        end else begin
          state_d  = IDLE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          acc_d    = '0;
          sticky_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      last_q   <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign IN_READY  = (state_q == IDLE) & ~RST;
  assign OUT_VALID = (state_q == DONE);
  assign RESULT    = result_q;
  assign OVF       = ovf_q;

endmodule
